// File: rtl/aegnn_pkg.sv
// Shared AEGNN definitions: datapath width and aggregator FSM states.
package aegnn_pkg;

    localparam int B_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } aggr_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational two's-complement adder that clamps to the W-bit range.
module sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum
);

    logic signed [W:0] w_full;

    assign w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};

    // Sign bit and carry-out disagreeing means the W-bit result wrapped.
    always_comb begin
        o_sum = w_full[W-1:0];
        if (w_full[W] != w_full[W-1]) begin
            if (w_full[W]) begin
                o_sum = {1'b1, {(W-1){1'b0}}};
            end else begin
                o_sum = {1'b0, {(W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/msg_aggregator.sv
// Sums per-edge messages of one node channel-wise with saturation and
// emits the aggregate as a single-cycle pulse.
module msg_aggregator
    import aegnn_pkg::*;
#(
    parameter int  OUT_C   = 32,
    parameter int  MAX_NBR = 16,
    localparam int CW      = $clog2(MAX_NBR + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OUT_C-1:0][B_WIDTH-1:0]   msg_pack,
    input  logic                            msg_valid,
    input  logic                            msg_last,
    output logic                            msg_ready,
    output logic [OUT_C-1:0][B_WIDTH-1:0]   aggr_pack,
    output logic                            aggr_valid,
    output logic [CW-1:0]                   aggr_nbr_cnt,
    output logic                            ovf_err
);

    aggr_state_t                      r_state;
    logic [OUT_C-1:0][B_WIDTH-1:0]    r_acc;
    logic [OUT_C-1:0][B_WIDTH-1:0]    r_aggr_pack;
    logic [CW-1:0]                    r_cnt;
    logic [CW-1:0]                    r_aggr_cnt;
    logic                             r_aggr_valid;
    logic                             r_ovf;

    logic [OUT_C-1:0][B_WIDTH-1:0]    w_sum;
    logic [OUT_C-1:0][B_WIDTH-1:0]    w_next;
    logic [CW-1:0]                    w_next_cnt;
    logic                             w_ready;
    logic                             w_accept;
    logic                             w_force;
    logic                             w_done;

    for (genvar g = 0; g < OUT_C; g++) begin : g_sat
        sat_add #(
            .W(B_WIDTH)
        ) u_sat (
            .i_a  (r_acc[g]),
            .i_b  (msg_pack[g]),
            .o_sum(w_sum[g])
        );
    end

    assign w_ready  = (r_state != ST_EMIT);
    assign w_accept = msg_valid && w_ready;

    // The first beat of a node loads directly so no accumulator clear is needed.
    assign w_next     = (r_state == ST_IDLE) ? msg_pack : w_sum;
    assign w_next_cnt = (r_state == ST_IDLE) ? CW'(1) : r_cnt + CW'(1);
    assign w_force    = !msg_last && (w_next_cnt == CW'(MAX_NBR));
    assign w_done     = msg_last || w_force;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_aggr_pack  <= '0;
            r_aggr_cnt   <= '0;
            r_aggr_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_aggr_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_next;
                        r_cnt <= w_next_cnt;
                        if (w_done) begin
                            r_state      <= ST_EMIT;
                            r_aggr_valid <= 1'b1;
                            r_aggr_pack  <= w_next;
                            r_aggr_cnt   <= w_next_cnt;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                        if (w_force) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                ST_EMIT: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign msg_ready    = w_ready;
    assign aggr_pack    = r_aggr_pack;
    assign aggr_valid   = r_aggr_valid;
    assign aggr_nbr_cnt = r_aggr_cnt;
    assign ovf_err      = r_ovf;

endmodule

// File: tb/tb_msg_aggregator.sv
// Directed self-checking bench for msg_aggregator (B_WIDTH=16, OUT_C=32).
module tb_msg_aggregator;
    import aegnn_pkg::*;

    localparam int OUT_C   = 32;
    localparam int MAX_NBR = 16;
    localparam int CW      = $clog2(MAX_NBR + 1);
    localparam int BW      = B_WIDTH;

    logic                          clk;
    logic                          rst;
    logic [OUT_C-1:0][BW-1:0]      msg_pack;
    logic                          msg_valid;
    logic                          msg_last;
    logic                          msg_ready;
    logic [OUT_C-1:0][BW-1:0]      aggr_pack;
    logic                          aggr_valid;
    logic [CW-1:0]                 aggr_nbr_cnt;
    logic                          ovf_err;

    int checks;
    int failures;
    int n_pulses;

    msg_aggregator #(
        .OUT_C  (OUT_C),
        .MAX_NBR(MAX_NBR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .msg_pack    (msg_pack),
        .msg_valid   (msg_valid),
        .msg_last    (msg_last),
        .msg_ready   (msg_ready),
        .aggr_pack   (aggr_pack),
        .aggr_valid  (aggr_valid),
        .aggr_nbr_cnt(aggr_nbr_cnt),
        .ovf_err     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (aggr_valid === 1'b1) n_pulses = n_pulses + 1;
    end

    function automatic bit all_eq(input logic signed [BW-1:0] v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < OUT_C; i++) begin
            if (aggr_pack[i] !== v) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic set_all(input logic signed [BW-1:0] v);
        for (int i = 0; i < OUT_C; i++) msg_pack[i] = v;
    endtask

    // Present one beat at a negedge; it is taken at the next posedge.
    task automatic send(input logic signed [BW-1:0] v, input logic last);
        set_all(v);
        msg_valid = 1'b1;
        msg_last  = last;
        @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        set_all('0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (aggr_valid !== 1'b0 || aggr_nbr_cnt !== '0 || ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: valid=%b cnt=%0d ovf=%b want 0 0 0",
                     aggr_valid, aggr_nbr_cnt, ovf_err);
        end
        checks++;
        if (!all_eq('0)) begin
            failures++;
            $display("FAIL reset_pack: ch0=%0d want 0", $signed(aggr_pack[0]));
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (msg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", msg_ready);
        end
    endtask

    task automatic test_three_beat();
        send(16'sd1, 1'b0);
        send(16'sd2, 1'b0);
        checks++;
        if (aggr_valid !== 1'b0) begin
            failures++;
            $display("FAIL three_early: valid=%b want 0", aggr_valid);
        end
        send(16'sd3, 1'b1);
        checks++;
        if (aggr_valid !== 1'b1 || !all_eq(16'sd6) || aggr_nbr_cnt !== CW'(3)) begin
            failures++;
            $display("FAIL three_pulse: valid=%b ch0=%0d cnt=%0d want 1 6 3",
                     aggr_valid, $signed(aggr_pack[0]), aggr_nbr_cnt);
        end
        @(negedge clk);
        checks++;
        if (aggr_valid !== 1'b0 || !all_eq(16'sd6) || aggr_nbr_cnt !== CW'(3)) begin
            failures++;
            $display("FAIL three_hold: valid=%b ch0=%0d cnt=%0d want 0 6 3",
                     aggr_valid, $signed(aggr_pack[0]), aggr_nbr_cnt);
        end
    endtask

    task automatic test_single();
        checks++;
        if (msg_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready_pre: got %b want 1", msg_ready);
        end
        send(-16'sd5, 1'b1);
        checks++;
        if (aggr_valid !== 1'b1 || !all_eq(-16'sd5) || aggr_nbr_cnt !== CW'(1)
            || msg_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: valid=%b ch0=%0d cnt=%0d rdy=%b want 1 -5 1 0",
                     aggr_valid, $signed(aggr_pack[0]), aggr_nbr_cnt, msg_ready);
        end
        @(negedge clk);
        checks++;
        if (aggr_valid !== 1'b0 || msg_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_after: valid=%b rdy=%b want 0 1", aggr_valid, msg_ready);
        end
    endtask

    task automatic test_saturation();
        send(16'sd32767, 1'b0);
        send(16'sd32767, 1'b0);
        send(-16'sd1, 1'b1);
        checks++;
        if (aggr_valid !== 1'b1 || !all_eq(16'sd32766) || aggr_nbr_cnt !== CW'(3)) begin
            failures++;
            $display("FAIL sat_pos: valid=%b ch0=%0d cnt=%0d want 1 32766 3",
                     aggr_valid, $signed(aggr_pack[0]), aggr_nbr_cnt);
        end
        @(negedge clk);
        send(-16'sd32768, 1'b0);
        send(-16'sd32768, 1'b0);
        send(16'sd1, 1'b1);
        checks++;
        if (aggr_valid !== 1'b1 || !all_eq(-16'sd32767)) begin
            failures++;
            $display("FAIL sat_neg: valid=%b ch0=%0d want 1 -32767",
                     aggr_valid, $signed(aggr_pack[0]));
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        checks++;
        if (ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pre: got %b want 0", ovf_err);
        end
        for (int i = 0; i < MAX_NBR - 1; i++) send(16'sd1, 1'b0);
        checks++;
        if (aggr_valid !== 1'b0 || ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_early: valid=%b ovf=%b want 0 0", aggr_valid, ovf_err);
        end
        send(16'sd1, 1'b0);
        checks++;
        if (aggr_valid !== 1'b1 || !all_eq(16'sd16) || aggr_nbr_cnt !== CW'(16)
            || ovf_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_pulse: valid=%b ch0=%0d cnt=%0d ovf=%b want 1 16 16 1",
                     aggr_valid, $signed(aggr_pack[0]), aggr_nbr_cnt, ovf_err);
        end
        @(negedge clk);
        send(16'sd2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ovf_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %b want 1", ovf_err);
        end
        do_reset();
        checks++;
        if (ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b want 0", ovf_err);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        send(16'sd5, 1'b0);
        send(16'sd5, 1'b0);
        p0 = n_pulses;
        do_reset();
        @(negedge clk);
        checks++;
        if (aggr_valid !== 1'b0 || !all_eq('0)) begin
            failures++;
            $display("FAIL mid_discard: valid=%b ch0=%0d want 0 0",
                     aggr_valid, $signed(aggr_pack[0]));
        end
        send(16'sd7, 1'b0);
        send(16'sd7, 1'b1);
        checks++;
        if (aggr_valid !== 1'b1 || !all_eq(16'sd14) || aggr_nbr_cnt !== CW'(2)) begin
            failures++;
            $display("FAIL mid_pulse: valid=%b ch0=%0d cnt=%0d want 1 14 2",
                     aggr_valid, $signed(aggr_pack[0]), aggr_nbr_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (n_pulses - p0 !== 1) begin
            failures++;
            $display("FAIL mid_count: pulses=%0d want 1", n_pulses - p0);
        end
    endtask

    task automatic test_emit_reset();
        send(16'sd4, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (aggr_valid !== 1'b0) begin
            failures++;
            $display("FAIL emit_rst: valid=%b want 0", aggr_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int vals [6];
        bit lasts [6];
        int pc [3];
        int pv [3];
        int pn [3];
        int np;
        int idx;
        bit acc;
        vals  = '{1, 1, 2, 2, 2, 9};
        lasts = '{0, 1, 0, 0, 1, 1};
        np  = 0;
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            if (aggr_valid === 1'b1 && np < 3) begin
                pc[np] = c;
                pv[np] = int'($signed(aggr_pack[0]));
                pn[np] = int'(aggr_nbr_cnt);
                np++;
            end
            if (idx < 6) begin
                set_all(BW'(vals[idx]));
                msg_valid = 1'b1;
                msg_last  = lasts[idx];
                acc = msg_ready;
            end else begin
                msg_valid = 1'b0;
                msg_last  = 1'b0;
                acc = 1'b0;
            end
            @(negedge clk);
            if (acc) idx++;
        end
        checks++;
        if (idx !== 6 || np !== 3) begin
            failures++;
            $display("FAIL b2b_count: beats=%0d pulses=%0d want 6 3", idx, np);
        end else begin
            checks++;
            if (pc[0] !== 2 || pc[1] !== 6 || pc[2] !== 8) begin
                failures++;
                $display("FAIL b2b_timing: cyc=%0d,%0d,%0d want 2,6,8",
                         pc[0], pc[1], pc[2]);
            end
            checks++;
            if (pv[0] !== 2 || pv[1] !== 6 || pv[2] !== 9
                || pn[0] !== 2 || pn[1] !== 3 || pn[2] !== 1) begin
                failures++;
                $display("FAIL b2b_data: val=%0d,%0d,%0d cnt=%0d,%0d,%0d want 2,6,9 2,3,1",
                         pv[0], pv[1], pv[2], pn[0], pn[1], pn[2]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n_pulses  = 0;
        rst       = 1'b1;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        msg_pack  = '0;
        @(negedge clk);
        test_reset();
        test_three_beat();
        test_single();
        test_saturation();
        test_overflow();
        test_reset_mid();
        test_emit_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_aggregator.md
MSG_AGGREGATOR -- requirements
Module: msg_aggregator

Interface
REQ-001 SHALL have parameter OUT_C, default 32, number of output channels per packet.
REQ-002 SHALL have parameter MAX_NBR, default 16, maximum number of messages per node before a forced emit.
REQ-003 SHALL import B_WIDTH from the shared aegnn package; every channel is a two's-complement value of B_WIDTH bits.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port msg_pack, input, OUT_C x B_WIDTH bits, per-edge message for all channels.
REQ-007 SHALL have port msg_valid, input, 1 bit, msg_pack holds a valid beat.
REQ-008 SHALL have port msg_last, input, 1 bit, the beat is the final message of the current node.
REQ-009 SHALL have port msg_ready, output, 1 bit, the block accepts a beat this cycle.
REQ-010 SHALL have port aggr_pack, output, OUT_C x B_WIDTH bits, aggregated sum, driving the bias/activation/quant stage.
REQ-011 SHALL have port aggr_valid, output, 1 bit, one-cycle pulse qualifying aggr_pack; no backpressure.
REQ-012 SHALL have port aggr_nbr_cnt, output, $clog2(MAX_NBR+1) bits, number of messages summed, valid with aggr_valid.
REQ-013 SHALL have port ovf_err, output, 1 bit, sticky flag set on a forced emit, cleared only by rst.

Function
REQ-014 SHALL accept a beat when msg_valid and msg_ready are both high in the same cycle.
REQ-015 SHALL implement an FSM with states IDLE, ACCUM and EMIT.
REQ-016 SHALL assert msg_ready in IDLE and ACCUM and deassert it in EMIT.
REQ-017 SHALL, on an accepted beat in IDLE, load the accumulator with msg_pack (no add) and set the count to 1.
REQ-018 SHALL, on an accepted beat in ACCUM, add msg_pack to the accumulator channel-wise and increment the count.
REQ-019 SHALL saturate each channel's sum to [-2^(B_WIDTH-1), 2^(B_WIDTH-1)-1]; it SHALL never wrap.
REQ-020 SHALL clamp an already-saturated channel on later adds while still allowing the opposite sign to pull it back.
REQ-021 SHALL transition to EMIT on an accepted beat with msg_last=1, from either IDLE or ACCUM.
REQ-022 SHALL go from IDLE to ACCUM on an accepted beat with msg_last=0.
REQ-023 SHALL transition to EMIT and set ovf_err when an accepted beat with msg_last=0 makes the count equal MAX_NBR.
REQ-024 SHALL, in EMIT, hold aggr_valid high for exactly one cycle with the final sum and count, then return to IDLE.
REQ-025 SHALL have a latency of one cycle: aggr_valid is asserted the cycle after the final beat is accepted.
REQ-026 SHALL support a minimum node period of 2 cycles (last beat plus EMIT), giving a sustained rate of one beat per cycle outside EMIT.
REQ-027 SHALL hold aggr_pack and aggr_nbr_cnt stable between pulses; both are registered outputs.
REQ-028 SHALL ignore msg_valid while msg_ready is low; the upstream block holds its beat.
REQ-029 SHALL leave state unchanged in IDLE and ACCUM when no beat is accepted.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, force the FSM to IDLE and aggr_valid, aggr_pack, aggr_nbr_cnt, the accumulator, the count and ovf_err to 0.
REQ-031 SHALL drive msg_ready high in the first cycle after rst deasserts.
REQ-032 SHALL discard any partial sum when rst is asserted mid-node, and SHALL not emit a pulse for it.
REQ-033 SHALL, when rst is asserted in EMIT, suppress aggr_valid in the following cycle.

Structure
REQ-034 SHALL take B_WIDTH from the aegnn package and SHALL add the FSM state enum type to that package.
REQ-035 SHALL instantiate OUT_C copies of one sub-module, sat_add, a combinational B_WIDTH signed saturating adder.
REQ-036 SHALL contain all sequential logic (FSM, counter, accumulator, output registers) in msg_aggregator itself.

Verification
REQ-037 SHALL cover a 3-beat node with all channels 1, 2, 3 and last on beat 3 -> one aggr_valid pulse the next cycle, all channels 6, aggr_nbr_cnt=3.
REQ-038 SHALL cover a single beat of value -5 with last=1 -> a pulse one cycle later with value -5, count 1, msg_ready low only in the EMIT cycle.
REQ-039 SHALL cover two beats of 2^(B_WIDTH-1)-1 followed by one beat of -1 -> sum 2^(B_WIDTH-1)-2, confirming saturation then recovery.
REQ-040 SHALL cover MAX_NBR=16 beats of value 1 with last never set -> a forced pulse of 16 with count 16 and ovf_err=1 held until rst.
REQ-041 SHALL cover rst after 2 of 4 beats, then a fresh 2-beat node of 7 -> exactly one pulse with value 14 and count 2.
REQ-042 SHALL cover back-to-back nodes with msg_valid held high -> no beat lost across EMIT, and pulses spaced by node length + 1 cycles.
